// File: rtl/score_countdown_multi_if.sv
// rtl/score_countdown_multi_if.sv - control/status bundle for the multi-player BCD score countdown
interface score_countdown_multi_if #(
    parameter int NUM_PLAYERS = 2,
    parameter int NUM_DIGITS  = 2
);
    localparam int SW = NUM_DIGITS * 4;
    localparam int WW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

    logic                        start;
    logic [NUM_PLAYERS-1:0]      correctkey;
    logic [NUM_PLAYERS*SW-1:0]   score;
    logic [NUM_PLAYERS-1:0]      ended;
    logic                        game_over;
    logic [WW-1:0]               winner;
    logic                        running;

    // Game host side: issues start and key levels, observes scores and status.
    modport master (
        output start,
        output correctkey,
        input  score,
        input  ended,
        input  game_over,
        input  winner,
        input  running
    );

    // Countdown engine side.
    modport slave (
        input  start,
        input  correctkey,
        output score,
        output ended,
        output game_over,
        output winner,
        output running
    );
endinterface

// File: rtl/score_countdown_multi.sv
// rtl/score_countdown_multi.sv - per-player BCD score countdown with first-to-zero winner detection
module score_countdown_multi #(
    parameter int                          NUM_PLAYERS = 2,
    parameter int                          NUM_DIGITS  = 2,
    parameter logic [NUM_DIGITS*4-1:0]     START_VALUE = 'h32
) (
    input  logic                  clk,
    input  logic                  resetn,
    score_countdown_multi_if.slave bus
);
    localparam int SW = NUM_DIGITS * 4;
    localparam int WW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                    r_state;
    logic [NUM_PLAYERS*SW-1:0] r_score;
    logic [NUM_PLAYERS-1:0]    r_ended;
    logic [NUM_PLAYERS-1:0]    r_key_prev;
    logic [WW-1:0]             r_winner;
    logic                      r_game_over;
    logic                      r_running;

    logic [NUM_PLAYERS-1:0]    w_edge;
    logic [NUM_PLAYERS*SW-1:0] w_dec_score;
    logic [NUM_PLAYERS-1:0]    w_hit;
    logic [WW-1:0]             w_win;

    // Subtract one from a packed BCD value, borrowing digit by digit (0 wraps to 9).
    function automatic logic [SW-1:0] bcd_dec(input logic [SW-1:0] v);
        logic [SW-1:0] r;
        logic          borrow;
        r      = v;
        borrow = 1'b1;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (borrow) begin
                if (v[d*4 +: 4] == 4'd0) begin
                    r[d*4 +: 4] = 4'd9;
                end else begin
                    r[d*4 +: 4] = v[d*4 +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Per-player edge detect, candidate decremented scores and zero-arrival detection.
    // Scanning from the top index down lets the lowest simultaneous arrival win.
    always_comb begin
        w_edge      = bus.correctkey & ~r_key_prev;
        w_dec_score = r_score;
        w_hit       = '0;
        w_win       = '0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (w_edge[i]) begin
                w_dec_score[i*SW +: SW] = bcd_dec(r_score[i*SW +: SW]);
                if (w_dec_score[i*SW +: SW] == '0) begin
                    w_hit[i] = 1'b1;
                    w_win    = WW'(i);
                end
            end
        end
    end

    // Game state machine; start overrides everything, key history tracks every cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_score     <= {NUM_PLAYERS{START_VALUE}};
            r_ended     <= '0;
            r_key_prev  <= '0;
            r_winner    <= '0;
            r_game_over <= 1'b0;
            r_running   <= 1'b0;
        end else begin
            r_key_prev <= bus.correctkey;
            if (bus.start) begin
                r_state     <= ST_RUN;
                r_score     <= {NUM_PLAYERS{START_VALUE}};
                r_ended     <= '0;
                r_winner    <= '0;
                r_game_over <= 1'b0;
                r_running   <= 1'b1;
            end else begin
                case (r_state)
                    ST_RUN: begin
                        r_score <= w_dec_score;
                        if (|w_hit) begin
                            r_ended     <= w_hit;
                            r_winner    <= w_win;
                            r_state     <= ST_DONE;
                            r_game_over <= 1'b1;
                            r_running   <= 1'b0;
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_DONE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.score     = r_score;
    assign bus.ended     = r_ended;
    assign bus.game_over = r_game_over;
    assign bus.winner    = r_winner;
    assign bus.running   = r_running;
endmodule

// File: tb/tb_score_countdown_multi.sv
// tb/tb_score_countdown_multi.sv - randomized model-checked bench for score_countdown_multi
module tb_score_countdown_multi;
    localparam int NP = 2;
    localparam int ND = 2;
    localparam logic [7:0] START_BCD = 8'h32;
    localparam int START_INT = 10 * int'(START_BCD[7:4]) + int'(START_BCD[3:0]);

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    logic armed  = 1'b0;

    int checks = 0;
    int errors = 0;

    score_countdown_multi_if #(.NUM_PLAYERS(NP), .NUM_DIGITS(ND)) u_if ();

    score_countdown_multi #(
        .NUM_PLAYERS(NP),
        .NUM_DIGITS (ND),
        .START_VALUE(START_BCD)
    ) u_dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (u_if)
    );

    always #5 clk = ~clk;

    // Reference model: integer scores, mode 0=idle 1=run 2=done.
    int          m_score [NP] = '{START_INT, START_INT};
    bit          m_prev  [NP] = '{1'b0, 1'b0};
    int          m_mode       = 0;
    bit [NP-1:0] m_ended      = '0;
    int          m_winner     = 0;

    always @(posedge clk or negedge resetn) begin
        int          ns [NP];
        bit [NP-1:0] e;
        int          w;
        if (!resetn) begin
            for (int i = 0; i < NP; i++) begin
                m_score[i] <= START_INT;
                m_prev[i]  <= 1'b0;
            end
            m_mode   <= 0;
            m_ended  <= '0;
            m_winner <= 0;
        end else begin
            for (int i = 0; i < NP; i++) m_prev[i] <= u_if.correctkey[i];
            if (u_if.start) begin
                for (int i = 0; i < NP; i++) m_score[i] <= START_INT;
                m_mode   <= 1;
                m_ended  <= '0;
                m_winner <= 0;
            end else if (m_mode == 1) begin
                e = '0;
                w = -1;
                for (int i = 0; i < NP; i++) begin
                    ns[i] = m_score[i];
                    if (u_if.correctkey[i] && !m_prev[i]) ns[i] = ns[i] - 1;
                    if (ns[i] == 0) begin
                        e[i] = 1'b1;
                        if (w < 0) w = i;
                    end
                    m_score[i] <= ns[i];
                end
                if (e != '0) begin
                    m_mode   <= 2;
                    m_ended  <= e;
                    m_winner <= w;
                end
            end
        end
    end

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[3:0] = 4'(v % 10);
        r[7:4] = 4'((v / 10) % 10);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        logic [15:0] exp_s;
        if (armed) begin
            for (int i = 0; i < NP; i++) exp_s[i*8 +: 8] = to_bcd(m_score[i]);
            check("score",     32'(u_if.score),     32'(exp_s));
            check("ended",     32'(u_if.ended),     32'(m_ended));
            check("game_over", 32'(u_if.game_over), (m_mode == 2) ? 32'd1 : 32'd0);
            check("running",   32'(u_if.running),   (m_mode == 1) ? 32'd1 : 32'd0);
            check("winner",    32'(u_if.winner),    (m_mode == 2) ? 32'(m_winner) : 32'd0);
        end
    end

    task automatic tick(input logic s, input logic [NP-1:0] k);
        u_if.start      = s;
        u_if.correctkey = k;
        @(posedge clk);
        #2;
    endtask

    initial begin
        u_if.start      = 1'b0;
        u_if.correctkey = '0;
        tick(1'b0, 2'b00);
        armed = 1'b1;
        tick(1'b0, 2'b00);
        resetn = 1'b1;
        check("reset_score", 32'(u_if.score), 32'h3232);

        // Keys in IDLE have no effect.
        tick(1'b0, 2'b11);
        tick(1'b0, 2'b00);
        tick(1'b0, 2'b11);
        check("idle_score",   32'(u_if.score),   32'h3232);
        check("idle_ended",   32'(u_if.ended),   32'h0);
        check("idle_running", 32'(u_if.running), 32'h0);

        // Three pulses on player 0 with borrow.
        tick(1'b1, 2'b00);
        tick(1'b0, 2'b01);
        check("p0_31", 32'(u_if.score[7:0]), 32'h31);
        tick(1'b0, 2'b00);
        tick(1'b0, 2'b01);
        check("p0_30", 32'(u_if.score[7:0]), 32'h30);
        tick(1'b0, 2'b00);
        tick(1'b0, 2'b01);
        check("p0_29", 32'(u_if.score[7:0]), 32'h29);
        check("p1_32", 32'(u_if.score[15:8]), 32'h32);

        // Held key gives one decrement; held across start gives none.
        tick(1'b1, 2'b00);
        repeat (10) tick(1'b0, 2'b10);
        check("hold_31", 32'(u_if.score[15:8]), 32'h31);
        tick(1'b1, 2'b10);
        repeat (3) tick(1'b0, 2'b10);
        check("hold_start", 32'(u_if.score[15:8]), 32'h32);

        // Player 1 counts down to zero and wins; then frozen.
        tick(1'b1, 2'b00);
        repeat (32) begin
            tick(1'b0, 2'b10);
            tick(1'b0, 2'b00);
        end
        check("p1_zero",   32'(u_if.score),     32'h0032);
        check("p1_ended",  32'(u_if.ended),     32'h2);
        check("p1_over",   32'(u_if.game_over), 32'h1);
        check("p1_winner", 32'(u_if.winner),    32'h1);
        repeat (5) begin
            tick(1'b0, 2'b11);
            tick(1'b0, 2'b00);
        end
        check("frozen", 32'(u_if.score), 32'h0032);

        // Simultaneous arrival resolves to player 0.
        tick(1'b1, 2'b00);
        check("restart_running", 32'(u_if.running), 32'h1);
        check("restart_ended",   32'(u_if.ended),   32'h0);
        repeat (31) begin
            tick(1'b0, 2'b11);
            tick(1'b0, 2'b00);
        end
        check("both_01", 32'(u_if.score), 32'h0101);
        tick(1'b0, 2'b11);
        check("both_00",     32'(u_if.score),  32'h0000);
        check("both_ended",  32'(u_if.ended),  32'h3);
        check("both_winner", 32'(u_if.winner), 32'h0);

        // Restart from DONE, then asynchronous reset mid-run.
        tick(1'b1, 2'b00);
        check("done_restart", 32'(u_if.score), 32'h3232);
        tick(1'b0, 2'b01);
        tick(1'b0, 2'b00);
        #1;
        resetn = 1'b0;
        #1;
        check("async_score",   32'(u_if.score),   32'h3232);
        check("async_running", 32'(u_if.running), 32'h0);
        tick(1'b0, 2'b00);
        resetn = 1'b1;
        tick(1'b0, 2'b01);
        check("post_reset_idle", 32'(u_if.score), 32'h3232);

        // Randomized play with occasional restarts and resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 599) == 0) begin
                #1;
                resetn = 1'b0;
                tick(1'b0, 2'b00);
                resetn = 1'b1;
            end
            tick(($urandom_range(0, 149) == 0) || (n == 0), 2'($urandom));
        end

        armed = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
